// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: widths, control encodings and the ID/EX
// control bundle used by the pipeline registers and the sign extender.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Write-back mux select carried on ResultSrc
  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } id_ex_ctrl_t;

  // Strip every bit that could change architectural state; mux selects are harmless.
  function automatic id_ex_ctrl_t to_bubble(input id_ex_ctrl_t c);
    id_ex_ctrl_t b;
    b           = c;
    b.reg_write = 1'b0;
    b.mem_read  = 1'b0;
    b.mem_write = 1'b0;
    b.branch    = 1'b0;
    b.jump      = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is a source of the
// instruction in ID. Purely combinational so a forwarding unit can reuse it.
module load_use_detect
  import rv32i_pkg::*;
(
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  output logic                  o_hz
);

  logic w_rd_nonzero;
  logic w_src_match;

  assign w_rd_nonzero = (i_ex_rd != '0);
  // rs2 is compared even for I-type: at worst one spurious bubble.
  assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_hz         = i_ex_valid & i_ex_mem_read & w_rd_nonzero & i_id_valid & w_src_match;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream stall and a saturating bubble counter.
module id_ex_pipeline_reg
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Stall_In,
  input  logic                  Flush_In,
  input  logic                  Valid_In,
  input  logic [XLEN-1:0]       PC_In,
  input  logic [XLEN-1:0]       Rs1_Data_In,
  input  logic [XLEN-1:0]       Rs2_Data_In,
  input  logic [XLEN-1:0]       Imm_Ext_In,
  input  logic [REG_ADDR_W-1:0] Rs1_Addr_In,
  input  logic [REG_ADDR_W-1:0] Rs2_Addr_In,
  input  logic [REG_ADDR_W-1:0] Rd_Addr_In,
  input  logic [2:0]            Funct3_In,
  input  logic [3:0]            ALU_Ctrl_In,
  input  logic                  ALUSrc_In,
  input  logic                  MemRead_In,
  input  logic                  MemWrite_In,
  input  logic                  RegWrite_In,
  input  logic                  Branch_In,
  input  logic                  Jump_In,
  input  logic [1:0]            ResultSrc_In,
  output logic [XLEN-1:0]       PC_Out,
  output logic [XLEN-1:0]       Rs1_Data_Out,
  output logic [XLEN-1:0]       Rs2_Data_Out,
  output logic [XLEN-1:0]       Imm_Ext_Out,
  output logic [REG_ADDR_W-1:0] Rs1_Addr_Out,
  output logic [REG_ADDR_W-1:0] Rs2_Addr_Out,
  output logic [REG_ADDR_W-1:0] Rd_Addr_Out,
  output logic [2:0]            Funct3_Out,
  output logic [3:0]            ALU_Ctrl_Out,
  output logic                  ALUSrc_Out,
  output logic                  MemRead_Out,
  output logic                  MemWrite_Out,
  output logic                  RegWrite_Out,
  output logic                  Branch_Out,
  output logic                  Jump_Out,
  output logic [1:0]            ResultSrc_Out,
  output logic                  Valid_Out,
  output logic                  Load_Use_Stall,
  output logic [CNT_W-1:0]      Bubble_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm_ext;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [2:0]            r_funct3;
  id_ex_ctrl_t           r_ctrl;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_bubble_count;

  id_ex_ctrl_t w_ctrl_in;
  logic        w_hz;
  logic        w_bubble;

  assign w_ctrl_in = '{
    reg_write:  RegWrite_In,
    mem_read:   MemRead_In,
    mem_write:  MemWrite_In,
    branch:     Branch_In,
    jump:       Jump_In,
    alu_src:    ALUSrc_In,
    result_src: ResultSrc_In,
    alu_ctrl:   ALU_Ctrl_In
  };

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd_addr),
    .i_id_valid    (Valid_In),
    .i_id_rs1      (Rs1_Addr_In),
    .i_id_rs2      (Rs2_Addr_In),
    .o_hz          (w_hz)
  );

  // Flush outranks stall; a hazard only bubbles when the register is free to move.
  assign w_bubble       = Flush_In | (~Stall_In & w_hz);
  assign Load_Use_Stall = w_hz & ~Flush_In & ~Stall_In;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm_ext  <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_funct3   <= '0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
    end else if (w_bubble) begin
      // Payload fields keep their old values; they are don't-care while invalid.
      r_valid   <= 1'b0;
      r_rd_addr <= '0;
      r_ctrl    <= to_bubble(w_ctrl_in);
    end else if (!Stall_In) begin
      r_pc       <= PC_In;
      r_rs1_data <= Rs1_Data_In;
      r_rs2_data <= Rs2_Data_In;
      r_imm_ext  <= Imm_Ext_In;
      r_rs1_addr <= Rs1_Addr_In;
      r_rs2_addr <= Rs2_Addr_In;
      r_rd_addr  <= Rd_Addr_In;
      r_funct3   <= Funct3_In;
      r_ctrl     <= w_ctrl_in;
      r_valid    <= Valid_In;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bubble_count <= '0;
    end else if (w_bubble && (r_bubble_count != CNT_MAX)) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign PC_Out        = r_pc;
  assign Rs1_Data_Out  = r_rs1_data;
  assign Rs2_Data_Out  = r_rs2_data;
  assign Imm_Ext_Out   = r_imm_ext;
  assign Rs1_Addr_Out  = r_rs1_addr;
  assign Rs2_Addr_Out  = r_rs2_addr;
  assign Rd_Addr_Out   = r_rd_addr;
  assign Funct3_Out    = r_funct3;
  assign ALU_Ctrl_Out  = r_ctrl.alu_ctrl;
  assign ALUSrc_Out    = r_ctrl.alu_src;
  assign MemRead_Out   = r_ctrl.mem_read;
  assign MemWrite_Out  = r_ctrl.mem_write;
  assign RegWrite_Out  = r_ctrl.reg_write;
  assign Branch_Out    = r_ctrl.branch;
  assign Jump_Out      = r_ctrl.jump;
  assign ResultSrc_Out = r_ctrl.result_src;
  assign Valid_Out     = r_valid;
  assign Bubble_Count  = r_bubble_count;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg; a second instance with a 2-bit
// counter exercises saturation in a handful of cycles.
module tb_id_ex_pipeline_reg;
  import rv32i_pkg::*;

  logic        Clk, Rst_n, Stall_In, Flush_In, Valid_In;
  logic [31:0] PC_In, Rs1_Data_In, Rs2_Data_In, Imm_Ext_In;
  logic [4:0]  Rs1_Addr_In, Rs2_Addr_In, Rd_Addr_In;
  logic [2:0]  Funct3_In;
  logic [3:0]  ALU_Ctrl_In;
  logic        ALUSrc_In, MemRead_In, MemWrite_In, RegWrite_In, Branch_In, Jump_In;
  logic [1:0]  ResultSrc_In;

  logic [31:0] PC_Out, Rs1_Data_Out, Rs2_Data_Out, Imm_Ext_Out;
  logic [4:0]  Rs1_Addr_Out, Rs2_Addr_Out, Rd_Addr_Out;
  logic [2:0]  Funct3_Out;
  logic [3:0]  ALU_Ctrl_Out;
  logic        ALUSrc_Out, MemRead_Out, MemWrite_Out, RegWrite_Out, Branch_Out, Jump_Out;
  logic [1:0]  ResultSrc_Out;
  logic        Valid_Out, Load_Use_Stall;
  logic [15:0] Bubble_Count;

  logic [31:0] s_pc, s_rs1d, s_rs2d, s_imm;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;
  logic [2:0]  s_f3;
  logic [3:0]  s_alu;
  logic        s_alusrc, s_memr, s_memw, s_regw, s_br, s_jmp;
  logic [1:0]  s_rsrc;
  logic        s_valid, s_lus;
  logic [1:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall_In(Stall_In), .Flush_In(Flush_In), .Valid_In(Valid_In),
    .PC_In(PC_In), .Rs1_Data_In(Rs1_Data_In), .Rs2_Data_In(Rs2_Data_In), .Imm_Ext_In(Imm_Ext_In),
    .Rs1_Addr_In(Rs1_Addr_In), .Rs2_Addr_In(Rs2_Addr_In), .Rd_Addr_In(Rd_Addr_In),
    .Funct3_In(Funct3_In), .ALU_Ctrl_In(ALU_Ctrl_In), .ALUSrc_In(ALUSrc_In),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .RegWrite_In(RegWrite_In),
    .Branch_In(Branch_In), .Jump_In(Jump_In), .ResultSrc_In(ResultSrc_In),
    .PC_Out(PC_Out), .Rs1_Data_Out(Rs1_Data_Out), .Rs2_Data_Out(Rs2_Data_Out),
    .Imm_Ext_Out(Imm_Ext_Out), .Rs1_Addr_Out(Rs1_Addr_Out), .Rs2_Addr_Out(Rs2_Addr_Out),
    .Rd_Addr_Out(Rd_Addr_Out), .Funct3_Out(Funct3_Out), .ALU_Ctrl_Out(ALU_Ctrl_Out),
    .ALUSrc_Out(ALUSrc_Out), .MemRead_Out(MemRead_Out), .MemWrite_Out(MemWrite_Out),
    .RegWrite_Out(RegWrite_Out), .Branch_Out(Branch_Out), .Jump_Out(Jump_Out),
    .ResultSrc_Out(ResultSrc_Out), .Valid_Out(Valid_Out), .Load_Use_Stall(Load_Use_Stall),
    .Bubble_Count(Bubble_Count)
  );

  id_ex_pipeline_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .Stall_In(Stall_In), .Flush_In(Flush_In), .Valid_In(Valid_In),
    .PC_In(PC_In), .Rs1_Data_In(Rs1_Data_In), .Rs2_Data_In(Rs2_Data_In), .Imm_Ext_In(Imm_Ext_In),
    .Rs1_Addr_In(Rs1_Addr_In), .Rs2_Addr_In(Rs2_Addr_In), .Rd_Addr_In(Rd_Addr_In),
    .Funct3_In(Funct3_In), .ALU_Ctrl_In(ALU_Ctrl_In), .ALUSrc_In(ALUSrc_In),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .RegWrite_In(RegWrite_In),
    .Branch_In(Branch_In), .Jump_In(Jump_In), .ResultSrc_In(ResultSrc_In),
    .PC_Out(s_pc), .Rs1_Data_Out(s_rs1d), .Rs2_Data_Out(s_rs2d),
    .Imm_Ext_Out(s_imm), .Rs1_Addr_Out(s_rs1a), .Rs2_Addr_Out(s_rs2a),
    .Rd_Addr_Out(s_rda), .Funct3_Out(s_f3), .ALU_Ctrl_Out(s_alu),
    .ALUSrc_Out(s_alusrc), .MemRead_Out(s_memr), .MemWrite_Out(s_memw),
    .RegWrite_Out(s_regw), .Branch_Out(s_br), .Jump_Out(s_jmp),
    .ResultSrc_Out(s_rsrc), .Valid_Out(s_valid), .Load_Use_Stall(s_lus),
    .Bubble_Count(s_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Valid_In     = 1'b0;
    PC_In        = '0;
    Rs1_Data_In  = '0;
    Rs2_Data_In  = '0;
    Imm_Ext_In   = '0;
    Rs1_Addr_In  = '0;
    Rs2_Addr_In  = '0;
    Rd_Addr_In   = '0;
    Funct3_In    = '0;
    ALU_Ctrl_In  = ALU_ADD;
    ALUSrc_In    = 1'b0;
    MemRead_In   = 1'b0;
    MemWrite_In  = 1'b0;
    RegWrite_In  = 1'b0;
    Branch_In    = 1'b0;
    Jump_In      = 1'b0;
    ResultSrc_In = RESULT_ALU;
  endtask

  initial begin
    Rst_n    = 1'b1;
    Stall_In = 1'b0;
    Flush_In = 1'b0;
    clr();
    #1 Rst_n = 1'b0;
    #2;
    check("rst_valid", Valid_Out, 0);
    check("rst_count", Bubble_Count, 0);
    check("rst_imm", Imm_Ext_Out, 0);
    check("rst_regwrite", RegWrite_Out, 0);
    check("rst_lus", Load_Use_Stall, 0);
    Rst_n = 1'b1;

    // Normal flow
    clr();
    Valid_In = 1'b1; PC_In = 32'h100; Imm_Ext_In = 32'hFFFFFFEA;
    Rd_Addr_In = 5'd5; RegWrite_In = 1'b1; Rs1_Addr_In = 5'd1; Rs2_Addr_In = 5'd2;
    Funct3_In = 3'd2; Rs1_Data_In = 32'hDEAD0001;
    #1 check("norm_lus_pre", Load_Use_Stall, 0);
    tick();
    check("norm_imm", Imm_Ext_Out, 32'hFFFFFFEA);
    check("norm_rd", Rd_Addr_Out, 5);
    check("norm_valid", Valid_Out, 1);
    check("norm_regwrite", RegWrite_Out, 1);
    check("norm_pc", PC_Out, 32'h100);
    check("norm_rs1data", Rs1_Data_Out, 32'hDEAD0001);
    check("norm_funct3", Funct3_Out, 2);
    check("norm_lus", Load_Use_Stall, 0);

    // Load-use via rs1: lw x5 then add x6, x5, x7
    clr();
    Valid_In = 1'b1; PC_In = 32'h104; MemRead_In = 1'b1; RegWrite_In = 1'b1;
    Rd_Addr_In = 5'd5; Rs1_Addr_In = 5'd2; ResultSrc_In = RESULT_MEM; ALUSrc_In = 1'b1;
    Imm_Ext_In = 32'h8;
    #1 check("lw_lus_pre", Load_Use_Stall, 0);
    tick();
    check("lw_memread", MemRead_Out, 1);
    check("lw_resultsrc", ResultSrc_Out, 1);
    check("lw_alusrc", ALUSrc_Out, 1);
    clr();
    Valid_In = 1'b1; PC_In = 32'h108; Rs1_Addr_In = 5'd5; Rs2_Addr_In = 5'd7;
    Rd_Addr_In = 5'd6; RegWrite_In = 1'b1;
    #1 check("lu_stall", Load_Use_Stall, 1);
    tick();
    check("lu_bub_valid", Valid_Out, 0);
    check("lu_bub_regwrite", RegWrite_Out, 0);
    check("lu_bub_memread", MemRead_Out, 0);
    check("lu_bub_rd", Rd_Addr_Out, 0);
    check("lu_bub_count", Bubble_Count, 1);
    check("lu_bub_pc_kept", PC_Out, 32'h104);
    check("lu_stall_clear", Load_Use_Stall, 0);
    tick();
    check("lu_re_valid", Valid_Out, 1);
    check("lu_re_rd", Rd_Addr_Out, 6);
    check("lu_re_pc", PC_Out, 32'h108);
    check("lu_re_count", Bubble_Count, 1);

    // Rs2 hazard, then flush in the same cycle
    clr();
    Valid_In = 1'b1; PC_In = 32'h10C; MemRead_In = 1'b1; RegWrite_In = 1'b1; Rd_Addr_In = 5'd8;
    Rs1_Addr_In = 5'd6;
    tick();
    clr();
    Valid_In = 1'b1; PC_In = 32'h110; Rs1_Addr_In = 5'd1; Rs2_Addr_In = 5'd8;
    Rd_Addr_In = 5'd4; RegWrite_In = 1'b1; Branch_In = 1'b1;
    #1 check("rs2_stall", Load_Use_Stall, 1);
    Flush_In = 1'b1;
    #1 check("flush_hz_lus", Load_Use_Stall, 0);
    tick();
    check("flush_valid", Valid_Out, 0);
    check("flush_regwrite", RegWrite_Out, 0);
    check("flush_branch", Branch_Out, 0);
    check("flush_rd", Rd_Addr_Out, 0);
    check("flush_count", Bubble_Count, 2);
    Flush_In = 1'b0;

    // Load to x0 never stalls
    clr();
    Valid_In = 1'b1; PC_In = 32'h114; MemRead_In = 1'b1; RegWrite_In = 1'b1; Rd_Addr_In = 5'd0;
    tick();
    check("x0_memread", MemRead_Out, 1);
    check("x0_rd", Rd_Addr_Out, 0);
    clr();
    Valid_In = 1'b1; PC_In = 32'h118; Rd_Addr_In = 5'd3; RegWrite_In = 1'b1;
    #1 check("x0_lus", Load_Use_Stall, 0);
    tick();
    check("x0_valid", Valid_Out, 1);
    check("x0_next_rd", Rd_Addr_Out, 3);
    check("x0_count", Bubble_Count, 2);

    // Downstream stall for 3 cycles with changing inputs (first two also hazard)
    clr();
    Valid_In = 1'b1; PC_In = 32'h200; Imm_Ext_In = 32'h11; Rd_Addr_In = 5'd9;
    MemRead_In = 1'b1; RegWrite_In = 1'b1;
    tick();
    check("st_load_rd", Rd_Addr_Out, 9);
    Stall_In = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clr();
      Valid_In = 1'b1; PC_In = 32'h204 + 32'(4 * k); Imm_Ext_In = 32'h22 + 32'(k);
      Rs1_Addr_In = (k < 2) ? 5'd9 : 5'd1; Rd_Addr_In = 5'd10 + 5'(k); RegWrite_In = 1'b1;
      #1 check("st_lus", Load_Use_Stall, 0);
      tick();
      check("st_rd", Rd_Addr_Out, 9);
      check("st_imm", Imm_Ext_Out, 32'h11);
      check("st_pc", PC_Out, 32'h200);
      check("st_valid", Valid_Out, 1);
      check("st_count", Bubble_Count, 2);
    end
    Stall_In = 1'b0;
    tick();
    check("rel_rd", Rd_Addr_Out, 12);
    check("rel_imm", Imm_Ext_Out, 32'h24);
    check("rel_pc", PC_Out, 32'h20C);
    check("rel_memread", MemRead_Out, 0);
    check("rel_count", Bubble_Count, 2);

    // Reset asserted mid-stall
    Stall_In = 1'b1;
    clr();
    Valid_In = 1'b1; Rd_Addr_In = 5'd13; Imm_Ext_In = 32'h44; RegWrite_In = 1'b1;
    tick();
    check("pre_rst_hold", Rd_Addr_Out, 12);
    #2 Rst_n = 1'b0;
    #1;
    check("mrst_valid", Valid_Out, 0);
    check("mrst_rd", Rd_Addr_Out, 0);
    check("mrst_imm", Imm_Ext_Out, 0);
    check("mrst_pc", PC_Out, 0);
    check("mrst_regwrite", RegWrite_Out, 0);
    check("mrst_count", Bubble_Count, 0);
    check("mrst_sat_count", s_count, 0);
    Rst_n = 1'b1;
    Stall_In = 1'b0;

    // Saturation: the 2-bit counter reaches max-1, then 3 more bubbles
    clr();
    Flush_In = 1'b1;
    tick();
    tick();
    check("sat_pre_small", s_count, 2);
    check("sat_pre_big", Bubble_Count, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat_small", s_count, 3);
      check("sat_big", Bubble_Count, 3 + k);
      check("sat_valid", Valid_Out, 0);
    end
    Flush_In = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register for the RV32I 5-stage core. It captures decoded operands, the sign-extended immediate (`Imm_Ext`) and control bits at the end of Decode, then presents them to Execute. It owns load-use hazard detection: on a hazard it inserts a bubble and freezes PC and IF/ID. It also handles branch/jump flush and downstream stall, and keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- `XLEN`, 32: datapath width
- `CNT_W`, 16: bubble counter width

Ports:
- `Clk` input 1: rising-edge clock
- `Rst_n` input 1: asynchronous, active-low reset
- `Stall_In` input 1: downstream hold; register keeps its contents
- `Flush_In` input 1: taken branch/jump resolved in EX; kill the entry being loaded
- `Valid_In` input 1: Decode holds a real instruction
- `PC_In`, `Rs1_Data_In`, `Rs2_Data_In`, `Imm_Ext_In` input XLEN: Decode payload
- `Rs1_Addr_In`, `Rs2_Addr_In`, `Rd_Addr_In` input 5: register indices
- `Funct3_In` input 3: funct3 field
- `ALU_Ctrl_In` input 4: ALU operation select
- `ALUSrc_In`, `MemRead_In`, `MemWrite_In`, `RegWrite_In`, `Branch_In`, `Jump_In` input 1 each: control bits
- `ResultSrc_In` input 2: write-back mux select
- `*_Out`: one registered output per payload/control input above, same widths
- `Valid_Out` output 1: the EX-stage entry is real
- `Load_Use_Stall` output 1: freeze PC and IF/ID this cycle
- `Bubble_Count` output CNT_W: number of bubbles inserted, saturating

## Operation
- Hazard (combinational): `hz = Valid_Out & MemRead_Out & (Rd_Addr_Out != 0) & Valid_In & ((Rd_Addr_Out == Rs1_Addr_In) | (Rd_Addr_Out == Rs2_Addr_In))`.
- `Load_Use_Stall = hz & ~Flush_In & ~Stall_In`.
- Per-edge action, in priority order:
  1. `Flush_In`: load a bubble.
  2. `Stall_In`: hold all registers.
  3. `hz`: load a bubble.
  4. Otherwise: load all inputs, with `Valid_Out <= Valid_In`.
- Bubble definition:
  - `Valid_Out=0`.
  - `RegWrite`, `MemRead`, `MemWrite`, `Branch` and `Jump` are forced to 0.
  - `Rd_Addr_Out=0`.
  - Data/PC/imm fields keep their previous values; they are don't-care while invalid.
- A bubble whose input is invalid (`Valid_In=0`) still zeroes control.
- Rs2 is compared even for I-type instructions. This is conservative and accepted: it costs at most one spurious bubble.
- `Bubble_Count` increments by 1 on every edge that loads a bubble due to `hz` or `Flush_In`. It holds at all-ones and never wraps.

## Timing
- Latency: 1 cycle, input to `*_Out`.
- `Load_Use_Stall` is combinational from the current `*_Out` and the ID inputs. It is high for exactly one cycle per load-use pair. On the next edge the bubble is in EX, so `hz` clears and the instruction re-presents.
- Simultaneous `Flush_In` and `hz`: flush wins and `Load_Use_Stall` stays 0, because the dependent instruction is itself being killed.
- Simultaneous `Stall_In` and `hz`: hold; `Load_Use_Stall` stays 0 and the counter does not increment.
- Reset (asynchronous assert, synchronous-style release on the next edge):
  - All outputs are 0, `Valid_Out=0`, `Bubble_Count=0`.
  - Reset mid-stall discards the held entry.

## Structure
- Shared package `rv32i_pkg`:
  - `XLEN`
  - `RESULT_ALU`/`RESULT_MEM`/`RESULT_PC4` encodings for `ResultSrc`
  - `ALU_Ctrl` encodings
  - `IMM_I`/`IMM_S`/`IMM_B`/`IMM_J` selects shared with the sign extender
  - a packed `id_ex_ctrl_t` struct: RegWrite, MemRead, MemWrite, Branch, Jump, ALUSrc, ResultSrc, ALU_Ctrl
- One sub-module, `load_use_detect`, holding the purely combinational `hz` equation. It can be reused by a future forwarding unit.

## Test plan
- Normal flow: `Valid_In=1`, `Imm_Ext_In=32'hFFFFFFEA`, `Rd=5`, `RegWrite=1` -> next cycle `Imm_Ext_Out=FFFFFFEA`, `Rd_Addr_Out=5`, `Valid_Out=1`, `Load_Use_Stall=0`.
- Load-use:
  - Stimulus: `lw x5` in EX (`MemRead_Out=1`, `Rd_Addr_Out=5`); ID presents `Rs1=5`.
  - Response: `Load_Use_Stall=1` for one cycle; next edge `Valid_Out=0`, `RegWrite_Out=0`, `Bubble_Count=1`; the re-presented instruction loads on the following edge.
- x0 load: `Rd_Addr_Out=0`, `MemRead_Out=1`, ID `Rs1=0` -> no stall, no bubble.
- Flush versus hazard:
  - Stimulus: `Flush_In=1` in the same cycle as `hz`.
  - Response: `Load_Use_Stall=0`; next `Valid_Out=0`; `Bubble_Count` increments exactly once.
- Stall:
  - Stimulus: `Stall_In=1` for 3 cycles while the inputs change.
  - Response: outputs frozen, no counter change; on release the current inputs load.
- Reset and saturation:
  - Drive `Rst_n=0` mid-stall -> all outputs 0 immediately.
  - Preload the counter to `16'hFFFE` and insert 3 bubbles -> `Bubble_Count=FFFF`.
